// File: rtl/mult_div_if.sv
// Handshake and operand/result bundle between the control unit and the multiply/divide unit.
// The control unit drives the starts and operands; the unit returns HI/LO and status pulses.
interface mult_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             mult_control;
    logic             DivOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             mult_end;
    logic             div_end;
    logic             div_zero;

    modport master (
        output mult_control, DivOp, A, B,
        input  HI, LO, busy, mult_end, div_end, div_zero
    );

    modport slave (
        input  mult_control, DivOp, A, B,
        output HI, LO, busy, mult_end, div_end, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential signed multiply (radix-2 Booth) / divide (restoring, on magnitudes) unit.
// Results land in HI/LO on entry to DONE; a one-cycle pulse flags completion.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic       clk,
    input logic       reset_in,
    mult_div_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {StIdle, StMult, StDiv, StDone, StDzero} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qm1_q, qm1_d;
    logic             last_q, last_d;
    logic             is_div_q, is_div_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] a_mag, b_mag, quot, rem;

    always_comb begin
        a_mag = bus.A[WIDTH-1] ? -bus.A : bus.A;
        b_mag = bus.B[WIDTH-1] ? -bus.B : bus.B;
        // One extra sign bit so acc - M cannot overflow when M is the most negative value.
        case ({q_q[0], qm1_q})
            2'b01:   booth_sum = {acc_q[WIDTH-1], acc_q} + {m_q[WIDTH-1], m_q};
            2'b10:   booth_sum = {acc_q[WIDTH-1], acc_q} - {m_q[WIDTH-1], m_q};
            default: booth_sum = {acc_q[WIDTH-1], acc_q};
        endcase
        trial = {acc_q, q_q[WIDTH-1]} - {1'b0, m_q};
        quot  = (sa_q ^ sb_q) ? -q_q : q_q;
        rem   = sa_q ? -acc_q : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        q_d      = q_q;
        m_d      = m_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        qm1_d    = qm1_q;
        last_d   = last_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            StIdle: begin
                last_d = 1'b0;
                cnt_d  = '0;
                if (bus.mult_control) begin
                    acc_d    = '0;
                    q_d      = bus.B;
                    m_d      = bus.A;
                    qm1_d    = 1'b0;
                    is_div_d = 1'b0;
                    state_d  = StMult;
                end else if (bus.DivOp) begin
                    if (bus.B == '0) begin
                        state_d = StDzero;
                    end else begin
                        acc_d    = '0;
                        q_d      = a_mag;
                        m_d      = b_mag;
                        sa_d     = bus.A[WIDTH-1];
                        sb_d     = bus.B[WIDTH-1];
                        is_div_d = 1'b1;
                        state_d  = StDiv;
                    end
                end
            end
            StMult, StDiv: begin
                // After the last iteration one more clock registers the (sign-fixed) result.
                if (last_q) begin
                    last_d  = 1'b0;
                    hi_d    = is_div_q ? rem : acc_q;
                    lo_d    = is_div_q ? quot : q_q;
                    state_d = StDone;
                end else begin
                    if (state_q == StMult) begin
                        acc_d = booth_sum[WIDTH:1];
                        q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
                        qm1_d = q_q[0];
                    end else if (!trial[WIDTH]) begin
                        acc_d = trial[WIDTH-1:0];
                        q_d   = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
                        q_d   = {q_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        cnt_d  = '0;
                        last_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StDone, StDzero: state_d = StIdle;
            default:         state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            q_q      <= '0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            qm1_q    <= 1'b0;
            last_q   <= 1'b0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            m_q      <= m_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            qm1_q    <= qm1_d;
            last_q   <= last_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
    assign bus.busy     = (state_q == StMult) || (state_q == StDiv) || (state_q == StDone);
    assign bus.mult_end = (state_q == StDone) && !is_div_q;
    assign bus.div_end  = (state_q == StDone) && is_div_q;
    assign bus.div_zero = (state_q == StDzero);
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: table of operations scored through an expectation queue,
// plus hand-written sequences for simultaneous starts and mid-operation reset.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mult_div_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset_in (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [2:0]  kind;  // {mult_end, div_end, div_zero}
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    typedef struct {
        logic        mul;
        logic        dv;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [2:0]  kind;
        int          busy;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vt[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Every completion pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && (bus.mult_end || bus.div_end || bus.div_zero)) begin
            if (sbq.size() == 0) begin
                check("spurious_pulse", {61'd0, bus.mult_end, bus.div_end, bus.div_zero}, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                check("pulse_kind", {61'd0, bus.mult_end, bus.div_end, bus.div_zero},
                      {61'd0, mon_e.kind});
                check("latency", 64'(cyc), 64'(mon_e.due));
                check("hi", {32'd0, bus.HI}, {32'd0, mon_e.hi});
                check("lo", {32'd0, bus.LO}, {32'd0, mon_e.lo});
            end
        end
    end

    task automatic run_op(input logic mul, input logic dv, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic [2:0] kind, input int exp_busy, input int late_div);
        int          busy_cnt = 0;
        int          unstable = 0;
        logic [31:0] ph, pl;
        exp_t        e;
        @(negedge clk);
        ph = bus.HI;
        pl = bus.LO;
        bus.mult_control = mul;
        bus.DivOp        = dv;
        bus.A            = a;
        bus.B            = b;
        e.kind = kind;
        e.hi   = eh;
        e.lo   = el;
        e.due  = cyc + 1 + ((kind == 3'b001) ? 0 : 33);
        sbq.push_back(e);
        @(negedge clk);
        #1;
        bus.mult_control = 1'b0;
        bus.DivOp        = 1'b0;
        bus.A            = $urandom;
        bus.B            = $urandom;
        for (int i = 0; i < 80; i++) begin
            bus.DivOp = (i == late_div);
            if (bus.busy) busy_cnt++;
            if (bus.busy && !bus.mult_end && !bus.div_end && (bus.HI !== ph || bus.LO !== pl))
                unstable++;
            if (!bus.busy && sbq.size() == 0 && i > late_div) break;
            @(negedge clk);
            #1;
        end
        bus.DivOp = 1'b0;
        check("op_done", 64'(sbq.size()), 64'd0);
        check("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
        check("hilo_stable", 64'(unstable), 64'd0);
        sbq.delete();
    endtask

    initial begin
        int idle_busy;
        vt[0]  = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 3'b100, 34};
        vt[1]  = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 3'b100, 34};
        vt[2]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 3'b010, 34};
        vt[3]  = '{1'b0, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       3'b010, 34};
        vt[4]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 3'b010, 34};
        vt[5]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 3'b100, 34};
        vt[6]  = '{1'b1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 3'b100, 34};
        vt[7]  = '{1'b0, 1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 3'b010, 34};
        vt[8]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 3'b010, 34};
        vt[9]  = '{1'b1, 1'b0, 32'h12345678, 32'd1,        32'h00000000, 32'h12345678, 3'b100, 34};
        // Divide by zero: HI/LO keep the previous result, no busy, pulse right after start.
        vt[10] = '{1'b0, 1'b1, 32'd5,        32'd0,        32'h00000000, 32'h12345678, 3'b001, 0};

        bus.mult_control = 1'b0;
        bus.DivOp        = 1'b0;
        bus.A            = '0;
        bus.B            = '0;
        repeat (3) @(negedge clk);
        check("reset_hi", {32'd0, bus.HI}, 64'd0);
        check("reset_lo", {32'd0, bus.LO}, 64'd0);
        check("reset_flags", {60'd0, bus.busy, bus.mult_end, bus.div_end, bus.div_zero}, 64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 11; k++)
            run_op(vt[k].mul, vt[k].dv, vt[k].a, vt[k].b, vt[k].hi, vt[k].lo,
                   vt[k].kind, vt[k].busy, -1);

        // Both starts together, then a stray DivOp mid-multiply: one multiply only.
        run_op(1'b1, 1'b1, 32'd3, 32'd4, 32'd0, 32'd12, 3'b100, 34, 5);
        idle_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy) idle_busy++;
        end
        check("no_queued_op", 64'(idle_busy), 64'd0);

        // Reset in the middle of a multiply aborts it with no end pulse.
        @(negedge clk);
        bus.mult_control = 1'b1;
        bus.A            = 32'd9;
        bus.B            = 32'd9;
        @(negedge clk);
        bus.mult_control = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_hi", {32'd0, bus.HI}, 64'd0);
        check("abort_lo", {32'd0, bus.LO}, 64'd0);
        check("abort_flags", {60'd0, bus.busy, bus.mult_end, bus.div_end, bus.div_zero}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_busy = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy) idle_busy++;
        end
        check("abort_no_resume", 64'(idle_busy), 64'd0);

        run_op(1'b1, 1'b0, 32'd5, 32'd6, 32'd0, 32'd30, 3'b100, 34, -1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
